game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Central game controller for the Mastermind design.
- Requests and latches a secret code from the PRNG, then accepts a guess on each select press and writes it to history.
- Scores each guess with a multi-cycle exact/partial engine, advances the turn counter, and declares win or loss.
- Feeds the feedback SSD path, the history write port and the turn LEDs.

Parameters:
- MAX_TURNS, 8, number of guesses allowed per game (TURN_W = clog2(MAX_TURNS)).
- COLOR_W, 3, bits per peg colour.
- PEGS, 4, pegs per code; fixed at 4 for this revision.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  play mode (switch low); select edges are ignored while 0.
- new_game  in  1  level; restarts the game whenever sampled high.
- select  in  1  debounced select level; the rising edge is detected internally.
- guess_in  in  12  {peg3,peg2,peg1,peg0}; peg0 = [2:0].
- code_req  out  1  high while waiting for a PRNG code.
- code_valid  in  1  PRNG code ready; sampled only when code_req = 1.
- code_in  in  12  secret code, same packing as guess_in.
- hist_we  out  1  one-cycle pulse writing guess_r to history.
- hist_addr  out  TURN_W  history slot = current turn.
- hist_data  out  12  latched guess.
- turn  out  TURN_W  current turn index, 0..MAX_TURNS-1.
- exact  out  3  correct colour and position, 0..4.
- partial  out  3  correct colour, wrong position, 0..4.
- fb_valid  out  1  one-cycle pulse when exact/partial update.
- busy  out  1  high in any state except PLAY and DONE.
- win  out  1  game won.
- game_over  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, code_r = 0, guess_r = 0, used flags cleared, select_q = 0.
- States: IDLE, REQ_CODE, PLAY, EXACT, PARTIAL, REPORT, DONE.
- IDLE -> REQ_CODE unconditionally on the next cycle.
- REQ_CODE: code_req = 1 (registered output, asserted in the same cycle the state is entered). On code_valid: latch code_r, set turn = 0, go to PLAY.
- PLAY: a select rise is select & ~select_q & enable.
  - On a rise at cycle T: guess_r <= guess_in, clear used flags and counters, idx <= 0, go to EXACT.
  - hist_we = 1 during T+1, with hist_addr = turn and hist_data = guess_r.
- EXACT (4 cycles, T+1..T+4), peg idx per cycle:
  - If guess_r[idx] == code_r[idx]: set gused[idx] and cused[idx], and increment the exact counter.
  - After idx = 3, go to PARTIAL with idx = 0.
- PARTIAL (4 cycles, T+5..T+8), guess peg idx per cycle:
  - Only when gused[idx] = 0: find the lowest j with cused[j] = 0 and code_r[j] == guess_r[idx].
  - If found, set cused[j] and increment the partial counter. Each code peg is credited at most once.
- REPORT (cycle T+9): exact/partial registered outputs take the counter values; fb_valid = 1. Next state:
  - exact == 4 -> DONE with win = 1.
  - else turn == MAX_TURNS-1 -> DONE with win = 0.
  - else turn += 1 -> PLAY.
- DONE: game_over = 1; turn, exact and partial hold; select is ignored.
- Latency: select rise to fb_valid is exactly 9 cycles.
- exact and partial hold between reports; they clear only on reset or new_game.
- select_q updates every cycle in every state. A select held high or re-pressed while busy never re-triggers; a rise seen outside PLAY is lost.
- new_game high in any state:
  - Next state REQ_CODE; turn, exact, partial, win and game_over clear; any in-flight score is aborted with no fb_valid.
  - new_game has priority over a select rise and over code_valid in the same cycle.
- enable low during scoring does not abort scoring; it only masks new select edges.
- code_valid outside REQ_CODE is ignored.
- Counters are 3-bit and saturate by construction (max 4); exact + partial <= 4 always.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared package mm_pkg holds:
  - constants PEGS, COLOR_W, MAX_TURNS and TURN_W;
  - the state enum;
  - the peg slice helper constant CODE_W = PEGS*COLOR_W.
- Natural sub-module: score_engine. It contains the EXACT/PARTIAL index counter, the used flags, the lowest-free-match priority encoder and the two counters, plus start/done handshake to the top FSM.

Test Plan:
- Code {4,3,2,1} (peg3..peg0), guess {4,3,2,1} -> fb_valid at T+9, exact = 4, partial = 0, win = 1, game_over = 1, hist_we at T+1 with addr 0.
- Same code, guess {1,2,3,4} -> exact = 0, partial = 4, turn advances to 1, state PLAY.
- Duplicates: code peg0..3 = 1,1,2,2; guess peg0..3 = 1,2,1,5 -> exact = 1, partial = 2.
- Eight wrong guesses {0,0,0,0} vs code {4,3,2,1} -> eighth report has exact = 0 and partial = 0; then win = 0, game_over = 1, turn = 7; further select gives no hist_we.
- Select held high for 50 cycles, plus a second press at T+4 -> exactly one fb_valid and one hist_we.
- new_game asserted at T+6 -> no fb_valid, code_req = 1 next cycle, turn = 0. A reset_n pulse mid-EXACT gives all outputs 0 asynchronously.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared Mastermind constants and sequencer state encoding
package mm_pkg;
  localparam int PEGS = 4;
  localparam int COLOR_W = 3;
  localparam int MAX_TURNS = 8;
  localparam int TURN_W = $clog2(MAX_TURNS);
  localparam int CODE_W = PEGS * COLOR_W;
  localparam int IDX_W = $clog2(PEGS);
  typedef enum logic [2:0] {IDLE, REQ_CODE, PLAY, EXACT, PARTIAL, REPORT, DONE} state_t;
endpackage

// File: rtl/game_sequencer_score_engine.sv
// score_engine: one peg per cycle, an exact pass then a partial pass over the latched guess
module score_engine
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              run,
  input  logic              ph,
  input  logic [CODE_W-1:0] guess,
  input  logic [CODE_W-1:0] code,
  output logic              last,
  output logic [2:0]        exact_cnt,
  output logic [2:0]        partial_cnt
);
  logic [IDX_W-1:0] idx, p_j;
  logic [PEGS-1:0] gused, cused;
  logic [2:0] ex_q, pa_q;
  logic [COLOR_W-1:0] g_peg;
  logic e_hit, p_hit;
  assign g_peg = guess[idx*COLOR_W +: COLOR_W];
  assign e_hit = !ph && g_peg == code[idx*COLOR_W +: COLOR_W];
  assign last = idx == IDX_W'(PEGS-1);
  assign exact_cnt = ex_q;
  // the final partial credit lands on the same edge the report registers it
  assign partial_cnt = pa_q + {2'b0, p_hit};
  always_comb begin
    p_hit = 1'b0;
    p_j = '0;
    for (int j = PEGS-1; j >= 0; j--)
      if (!cused[j] && code[j*COLOR_W +: COLOR_W] == g_peg) begin
        p_hit = 1'b1;
        p_j = IDX_W'(j);
      end
    p_hit = p_hit && ph && !gused[idx];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      gused <= '0;
      cused <= '0;
      ex_q <= '0;
      pa_q <= '0;
    end else if (start) begin
      idx <= '0;
      gused <= '0;
      cused <= '0;
      ex_q <= '0;
      pa_q <= '0;
    end else if (run) begin
      idx <= idx + 1'b1;
      if (e_hit) begin
        gused[idx] <= 1'b1;
        cused[idx] <= 1'b1;
        ex_q <= ex_q + 3'd1;
      end
      if (p_hit) begin
        cused[p_j] <= 1'b1;
        pa_q <= pa_q + 3'd1;
      end
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Mastermind game controller -- code fetch, guess capture, scoring and win/loss
module game_sequencer
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              new_game,
  input  logic              select,
  input  logic [CODE_W-1:0] guess_in,
  output logic              code_req,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  output logic              hist_we,
  output logic [TURN_W-1:0] hist_addr,
  output logic [CODE_W-1:0] hist_data,
  output logic [TURN_W-1:0] turn,
  output logic [2:0]        exact,
  output logic [2:0]        partial,
  output logic              fb_valid,
  output logic              busy,
  output logic              win,
  output logic              game_over
);
  state_t state, state_n;
  logic [CODE_W-1:0] code_r, guess_r;
  logic [2:0] exact_cnt, partial_cnt;
  logic select_q, rise, last, start, fb;
  assign rise = select && !select_q && enable;
  assign start = state == PLAY && state_n == EXACT;
  assign fb = state == PARTIAL && state_n == REPORT;
  assign hist_addr = turn;
  assign hist_data = guess_r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = REQ_CODE;
      REQ_CODE: state_n = code_valid ? PLAY : REQ_CODE;
      PLAY:     state_n = rise ? EXACT : PLAY;
      EXACT:    state_n = last ? PARTIAL : EXACT;
      PARTIAL:  state_n = last ? REPORT : PARTIAL;
      REPORT:   state_n = (exact == 3'(PEGS) || turn == TURN_W'(MAX_TURNS-1)) ? DONE : PLAY;
      default:  state_n = DONE;
    endcase
    if (new_game) state_n = REQ_CODE;
  end
  score_engine u_score (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .run        (state == EXACT || state == PARTIAL),
    .ph         (state == PARTIAL),
    .guess      (guess_r),
    .code       (code_r),
    .last       (last),
    .exact_cnt  (exact_cnt),
    .partial_cnt(partial_cnt)
  );
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      code_r <= '0;
      guess_r <= '0;
      select_q <= 1'b0;
      turn <= '0;
      exact <= '0;
      partial <= '0;
      code_req <= 1'b0;
      hist_we <= 1'b0;
      fb_valid <= 1'b0;
      busy <= 1'b0;
      win <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      select_q <= select;
      code_req <= state_n == REQ_CODE;
      busy <= !(state_n inside {PLAY, DONE});
      game_over <= state_n == DONE;
      hist_we <= start;
      fb_valid <= fb;
      if (state == REQ_CODE && state_n == PLAY) begin
        code_r <= code_in;
        turn <= '0;
      end
      if (start) guess_r <= guess_in;
      if (fb) begin
        exact <= exact_cnt;
        partial <= partial_cnt;
      end
      if (state == REPORT && state_n == PLAY) turn <= turn + 1'b1;
      if (state == REPORT && state_n == DONE) win <= exact == 3'(PEGS);
      if (new_game) begin
        turn <= '0;
        exact <= '0;
        partial <= '0;
        win <= 1'b0;
      end
    end
endmodule
